// File: rtl/fetch_stage_pkg.sv
// Shared processor parameters for the fetch stage: widths, opcodes, the NOP word and FSM encodings.
// Optional build macro used by the importing files: FETCH_PREFETCH_EN.
package fetch_stage_pkg;

  localparam int PC_WIDTH     = 16;
  localparam int INSTR_WIDTH  = 32;
  localparam int OPCODE_WIDTH = 6;

  localparam logic [OPCODE_WIDTH-1:0] NOP  = 6'h00;
  localparam logic [OPCODE_WIDTH-1:0] JR   = 6'h11;
  localparam logic [OPCODE_WIDTH-1:0] JPC  = 6'h12;
  localparam logic [OPCODE_WIDTH-1:0] BRFL = 6'h13;
  localparam logic [OPCODE_WIDTH-1:0] CALL = 6'h14;
  localparam logic [OPCODE_WIDTH-1:0] RET  = 6'h15;

  // Opcode sits in the top bits; every other field of the bubble word is zero.
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = {NOP, {(INSTR_WIDTH-OPCODE_WIDTH){1'b0}}};

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
  } fetch_word_t;

  function automatic logic [PC_WIDTH-1:0] pc_next(input logic [PC_WIDTH-1:0] pc);
    return pc + PC_ONE;
  endfunction

endpackage

// File: rtl/fetch_prefetch_buf.sv
// Single-entry holding buffer for a word fetched while decode is stalled.
// Only compiled when FETCH_PREFETCH_EN is defined.
`ifdef FETCH_PREFETCH_EN
module fetch_prefetch_buf
  import fetch_stage_pkg::*;
(
  input  logic                   clk_in,
  input  logic                   RST,
  input  logic                   clear_i,
  input  logic                   load_i,
  input  logic                   drain_i,
  input  fetch_word_t            load_word_i,
  output logic [INSTR_WIDTH-1:0] buf_instr_o,
  output logic [PC_WIDTH-1:0]    buf_pc_o,
  output logic                   buf_valid_o
);

  fetch_word_t word_q;
  logic        valid_q;

  // Clear beats load beats drain; load and drain are never requested together.
  always_ff @(posedge clk_in or negedge RST) begin
    if (!RST) begin
      word_q  <= '0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      word_q  <= load_word_i;
      valid_q <= 1'b1;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign buf_instr_o = word_q.instr;
  assign buf_pc_o    = word_q.pc;
  assign buf_valid_o = valid_q;

endmodule
`endif

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and feeds decode.
// Define FETCH_PREFETCH_EN to add a one-entry buffer that keeps fetching during a stall.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk_in,
  input  logic                   RST,
  input  logic                   stall,
  input  logic                   flush_en,
  input  logic [PC_WIDTH-1:0]    flush_pc,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic                   valid
);

  logic [0:0]             state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    pc_out_q, pc_out_d;
  logic                   valid_q, valid_d;

  logic                   run;
  logic                   accept;
  logic                   xfer;
  logic [PC_WIDTH-1:0]    pc_plus1;

  assign run      = (state_q == ST_RUN);
  assign accept   = !valid_q || !stall;
  assign pc_plus1 = pc_next(pc_q);
  assign xfer     = imem_req && imem_ack;

`ifdef FETCH_PREFETCH_EN
  logic                   buf_valid;
  logic [INSTR_WIDTH-1:0] buf_instr;
  logic [PC_WIDTH-1:0]    buf_pc;
  fetch_word_t            load_word;

  assign load_word = '{instr: imem_data, pc: pc_plus1};
  assign imem_req  = run && !buf_valid;

  fetch_prefetch_buf u_prefetch_buf (
    .clk_in      (clk_in),
    .RST         (RST),
    .clear_i     (flush_en),
    .load_i      (!flush_en && !accept && xfer),
    .drain_i     (!flush_en && accept && buf_valid),
    .load_word_i (load_word),
    .buf_instr_o (buf_instr),
    .buf_pc_o    (buf_pc),
    .buf_valid_o (buf_valid)
  );
`else
  assign imem_req = run && accept;
`endif

  // Flush wins over everything; a buffered word drains ahead of fresh memory data.
  always_comb begin
    state_d  = ST_RUN;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    if (flush_en) begin
      pc_d    = flush_pc;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (accept) begin
`ifdef FETCH_PREFETCH_EN
      if (buf_valid) begin
        instr_d  = buf_instr;
        pc_out_d = buf_pc;
        valid_d  = 1'b1;
      end else
`endif
      if (xfer) begin
        instr_d  = imem_data;
        pc_out_d = pc_plus1;
        valid_d  = 1'b1;
        pc_d     = pc_plus1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end else if (xfer) begin
      pc_d = pc_plus1;
    end
  end

  always_ff @(posedge clk_in or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign pc_out    = pc_out_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed walk-through plus randomized traffic against a queue-based model.
// Honours FETCH_PREFETCH_EN the same way the design does.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic                   clock = 1'b0;
  logic                   rstN = 1'b0;
  logic                   stall = 1'b0;
  logic                   flushEn = 1'b0;
  logic [PC_WIDTH-1:0]    flushPc = '0;
  logic                   imemAck = 1'b0;
  logic                   imemReq;
  logic [PC_WIDTH-1:0]    imemAddr;
  logic [INSTR_WIDTH-1:0] imemData;
  logic [INSTR_WIDTH-1:0] instr;
  logic [PC_WIDTH-1:0]    pcOut;
  logic                   valid;
  bit                     memMode = 1'b0;

  int checks = 0;
  int failures = 0;

`ifdef FETCH_PREFETCH_EN
  localparam bit PREFETCH = 1'b1;
`else
  localparam bit PREFETCH = 1'b0;
`endif

  always #5 clock = ~clock;

  fetch_stage dut (
    .clk_in    (clock),
    .RST       (rstN),
    .stall     (stall),
    .flush_en  (flushEn),
    .flush_pc  (flushPc),
    .imem_req  (imemReq),
    .imem_addr (imemAddr),
    .imem_ack  (imemAck),
    .imem_data (imemData),
    .instr     (instr),
    .pc_out    (pcOut),
    .valid     (valid)
  );

  // Instruction memory contents: address<<4 for the directed part, a scrambled word later.
  function automatic logic [INSTR_WIDTH-1:0] memWord(input logic [PC_WIDTH-1:0] a, input bit mode);
    logic [PC_WIDTH-1:0] lo;
    lo = a * 16'd7 + 16'h1234;
    if (mode) return {a ^ 16'h5A3C, lo};
    return {12'h000, a, 4'h0};
  endfunction

  assign imemData = memWord(imemAddr, memMode);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit a, input bit f, input logic [PC_WIDTH-1:0] fpc);
    @(negedge clock);
    rstN    = r;
    stall   = s;
    imemAck = a;
    flushEn = f;
    flushPc = fpc;
  endtask

  // Behavioural model: program counter, pending-word queue and the output slot.
  typedef struct {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
  } bufEntry_t;

  bufEntry_t              mBuf[$];
  bit                     mRunning;
  logic [PC_WIDTH-1:0]    mPc;
  logic [PC_WIDTH-1:0]    mPcOut;
  logic [INSTR_WIDTH-1:0] mInstr;
  bit                     mValid;

  function automatic void modelReset();
    mRunning = 1'b0;
    mPc      = '0;
    mPcOut   = '0;
    mInstr   = NOP_INSTR;
    mValid   = 1'b0;
    mBuf.delete();
  endfunction

  function automatic bit modelReq();
    if (!mRunning) return 1'b0;
    if (PREFETCH) return mBuf.size() == 0;
    return !mValid || !stall;
  endfunction

  function automatic void modelStep();
    bit                     canTake;
    bit                     got;
    logic [INSTR_WIDTH-1:0] word;
    bufEntry_t              e;
    canTake = !mValid || !stall;
    got     = modelReq() && imemAck;
    word    = memWord(mPc, memMode);
    if (flushEn) begin
      mPc    = flushPc;
      mValid = 1'b0;
      mInstr = NOP_INSTR;
      mBuf.delete();
    end else if (canTake && mBuf.size() > 0) begin
      e      = mBuf.pop_front();
      mInstr = e.instr;
      mPcOut = e.pc;
      mValid = 1'b1;
    end else if (canTake && got) begin
      mInstr = word;
      mPcOut = mPc + 16'd1;
      mValid = 1'b1;
      mPc    = mPc + 16'd1;
    end else if (canTake) begin
      mInstr = NOP_INSTR;
      mValid = 1'b0;
    end else if (got) begin
      e.instr = word;
      e.pc    = mPc + 16'd1;
      mBuf.push_back(e);
      mPc = mPc + 16'd1;
    end
    mRunning = 1'b1;
  endfunction

  initial modelReset();

  // Compare every cycle, mid-way between edges, then advance the model across the coming edge.
  always begin
    @(negedge clock);
    #2;
    if (!rstN) modelReset();
    checkOutput("imem_req", imemReq, modelReq());
    checkOutput("imem_addr", imemAddr, mPc);
    checkOutput("valid", valid, mValid);
    checkOutput("instr", instr, mInstr);
    if (mValid || !rstN) checkOutput("pc_out", pcOut, mPcOut);
    if (rstN) modelStep();
  end

  initial begin
    $display("[TB] fetch_stage bench start, prefetch=%0d", PREFETCH);
    memMode = 1'b0;

    applyStimulus(0, 0, 1, 0, 0); #2;
    checkOutput("lit_rst_req", imemReq, 0);
    checkOutput("lit_rst_valid", valid, 0);
    checkOutput("lit_rst_instr", instr, NOP_INSTR);
    checkOutput("lit_rst_pcout", pcOut, 0);
    checkOutput("lit_rst_addr", imemAddr, 0);

    applyStimulus(1, 0, 1, 0, 0); #2;
    checkOutput("lit_boot_req", imemReq, 0);
    applyStimulus(1, 0, 1, 0, 0); #2;
    checkOutput("lit_first_req", imemReq, 1);
    checkOutput("lit_first_addr", imemAddr, 0);
    applyStimulus(1, 0, 1, 0, 0); #2;
    checkOutput("lit_i0", instr, 32'h00);
    checkOutput("lit_pc1", pcOut, 1);
    checkOutput("lit_v1", valid, 1);
    applyStimulus(1, 0, 1, 0, 0); #2;
    checkOutput("lit_i1", instr, 32'h10);
    checkOutput("lit_pc2", pcOut, 2);
    applyStimulus(1, 0, 1, 0, 0); #2;
    checkOutput("lit_i2", instr, 32'h20);
    checkOutput("lit_addr3", imemAddr, 3);
    applyStimulus(1, 0, 1, 0, 0);

    applyStimulus(1, 1, 1, 0, 0); #2;
    checkOutput("lit_stall_pc", pcOut, 5);
    checkOutput("lit_stall_req", imemReq, PREFETCH);
    applyStimulus(1, 1, 1, 0, 0); #2;
    checkOutput("lit_stall_hold", instr, 32'h40);
    checkOutput("lit_stall_req2", imemReq, 0);
    applyStimulus(1, 1, 1, 0, 0); #2;
    checkOutput("lit_stall_pc3", pcOut, 5);
    applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(1, 0, 1, 0, 0); #2;
    checkOutput("lit_resume_pc", pcOut, 6);
    checkOutput("lit_resume_instr", instr, 32'h50);

    applyStimulus(1, 0, 1, 1, 16'd1024); #2;
    checkOutput("lit_preflush_pc", pcOut, 7);
    checkOutput("lit_preflush_addr", imemAddr, 7);
    applyStimulus(1, 0, 1, 0, 0); #2;
    checkOutput("lit_flush_valid", valid, 0);
    checkOutput("lit_flush_instr", instr, NOP_INSTR);
    checkOutput("lit_flush_addr", imemAddr, 1024);
    applyStimulus(1, 0, 1, 1, 16'hFFFF); #2;
    checkOutput("lit_redirect_pc", pcOut, 1025);
    checkOutput("lit_redirect_instr", instr, 32'h4000);
    applyStimulus(1, 0, 1, 0, 0); #2;
    checkOutput("lit_wrap_addr", imemAddr, 16'hFFFF);
    applyStimulus(1, 0, 1, 0, 0); #2;
    checkOutput("lit_wrap_pcout", pcOut, 0);
    checkOutput("lit_wrap_next", imemAddr, 0);
    applyStimulus(1, 0, 1, 0, 0);

    applyStimulus(1, 0, 0, 0, 0); #2;
    checkOutput("lit_noack_pc", pcOut, 2);
    applyStimulus(1, 0, 0, 0, 0); #2;
    checkOutput("lit_noack_valid", valid, 0);
    checkOutput("lit_noack_req", imemReq, 1);
    checkOutput("lit_noack_addr", imemAddr, 2);
    applyStimulus(1, 0, 0, 0, 0); #2;
    checkOutput("lit_noack_addr2", imemAddr, 2);
    checkOutput("lit_noack_instr", instr, NOP_INSTR);
    applyStimulus(0, 0, 0, 0, 0); #2;
    checkOutput("lit_midrst_addr", imemAddr, 0);
    checkOutput("lit_midrst_req", imemReq, 0);
    checkOutput("lit_midrst_pcout", pcOut, 0);
    applyStimulus(1, 0, 1, 0, 0); #2;
    checkOutput("lit_reboot_req", imemReq, 0);
    applyStimulus(1, 0, 1, 0, 0); #2;
    checkOutput("lit_refetch_addr", imemAddr, 0);
    checkOutput("lit_refetch_req", imemReq, 1);

`ifdef FETCH_PREFETCH_EN
    applyStimulus(1, 1, 1, 0, 0); #2;
    checkOutput("lit_pf_fill_req", imemReq, 1);
    applyStimulus(1, 1, 1, 1, 16'd300); #2;
    checkOutput("lit_pf_full_req", imemReq, 0);
    applyStimulus(1, 0, 1, 0, 0); #2;
    checkOutput("lit_pf_flush_valid", valid, 0);
    checkOutput("lit_pf_flush_addr", imemAddr, 300);
    applyStimulus(1, 0, 1, 0, 0); #2;
    checkOutput("lit_pf_flush_pcout", pcOut, 301);
    checkOutput("lit_pf_flush_instr", instr, 32'h12C0);
`endif

    memMode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bit                  r, s, a, f;
      logic [PC_WIDTH-1:0] fpc;
      r   = ($urandom_range(0, 199) != 0);
      s   = ($urandom_range(0, 2) == 0);
      a   = ($urandom_range(0, 3) != 0);
      f   = ($urandom_range(0, 15) == 0);
      fpc = ($urandom_range(0, 3) == 0) ? (16'hFFFE | 16'($urandom_range(0, 1)))
                                        : 16'($urandom_range(0, 65535));
      applyStimulus(r, s, a, f, fpc);
    end

    applyStimulus(1, 0, 1, 0, 0);
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
